// File: rtl/alu_op_issuer.sv
// alu_op_issuer: issues one operation at a time to alu_design and returns RES/flags.
// Define ALU_ISSUE_SPLIT_EN to send OPA and OPB in separate cycles (SPLIT_GAP idle between).
module alu_op_issuer #(
    parameter int WIDTH     = 8,
    parameter int CMD_W     = 4,
    parameter int LAT_NORM  = 1,
    parameter int LAT_MUL   = 2,
    parameter int SPLIT_GAP = 0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_opa,
    input  logic [WIDTH-1:0]   req_opb,
    input  logic [CMD_W-1:0]   req_cmd,
    input  logic               req_mode,
    input  logic               req_cin,
    output logic [WIDTH-1:0]   OPA,
    output logic [WIDTH-1:0]   OPB,
    output logic [CMD_W-1:0]   CMD,
    output logic               MODE,
    output logic               CIN,
    output logic               CE,
    output logic [1:0]         INP_VALID,
    input  logic [2*WIDTH-1:0] RES,
    input  logic               COUT,
    input  logic               OFLOW,
    input  logic               G,
    input  logic               E,
    input  logic               L,
    input  logic               ERR,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_res,
    output logic [5:0]         rsp_flags,
    output logic [7:0]         err_cnt
);

    localparam int MAX_A = (LAT_MUL > LAT_NORM) ? LAT_MUL : LAT_NORM;
    localparam int MAX_C = (SPLIT_GAP > MAX_A) ? SPLIT_GAP : MAX_A;
    localparam int CNT_W = $clog2(MAX_C + 1);

    localparam logic [CNT_W-1:0] NORM_M1 = CNT_W'(LAT_NORM - 1);
    localparam logic [CNT_W-1:0] MUL_M1  = CNT_W'(LAT_MUL - 1);

`ifdef ALU_ISSUE_SPLIT_EN
    localparam logic [CNT_W-1:0] GAP_M1 =
        CNT_W'((SPLIT_GAP > 0) ? SPLIT_GAP - 1 : 0);

    typedef enum logic [2:0] {
        IDLE, SEND_A, GAP, SEND_B, WAIT, HOLD
    } state_e;

    logic [WIDTH-1:0] opb_sav_q, opb_sav_d;
`else
    typedef enum logic [1:0] {
        IDLE, SEND, WAIT, HOLD
    } state_e;
`endif

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mul_q, mul_d;
    logic               req_ready_q, req_ready_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    logic               mode_q, mode_d;
    logic               cin_q, cin_d;
    logic               ce_q, ce_d;
    logic [1:0]         inp_valid_q, inp_valid_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [2*WIDTH-1:0] rsp_res_q, rsp_res_d;
    logic [5:0]         rsp_flags_q, rsp_flags_d;
    logic [7:0]         err_cnt_q, err_cnt_d;

    // Next-state and registered-output logic for the issue sequence
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mul_d       = mul_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        cmd_d       = cmd_q;
        mode_d      = mode_q;
        cin_d       = cin_q;
        ce_d        = ce_q;
        inp_valid_d = inp_valid_q;
        rsp_valid_d = rsp_valid_q;
        rsp_res_d   = rsp_res_q;
        rsp_flags_d = rsp_flags_q;
        err_cnt_d   = err_cnt_q;
`ifdef ALU_ISSUE_SPLIT_EN
        opb_sav_d   = opb_sav_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    opa_d  = req_opa;
                    cmd_d  = req_cmd;
                    mode_d = req_mode;
                    cin_d  = req_cin;
                    mul_d  = req_mode &&
                             (req_cmd == CMD_W'(9) ||
                              req_cmd == CMD_W'(10));
                    ce_d   = 1'b1;
`ifdef ALU_ISSUE_SPLIT_EN
                    opb_d       = '0;
                    opb_sav_d   = req_opb;
                    inp_valid_d = 2'b01;
                    state_d     = SEND_A;
`else
                    opb_d       = req_opb;
                    inp_valid_d = 2'b11;
                    state_d     = SEND;
`endif
                end
            end
`ifdef ALU_ISSUE_SPLIT_EN
            SEND_A: begin
                if (SPLIT_GAP == 0) begin
                    opb_d       = opb_sav_q;
                    inp_valid_d = 2'b10;
                    state_d     = SEND_B;
                end else begin
                    inp_valid_d = 2'b00;
                    cnt_d       = GAP_M1;
                    state_d     = GAP;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    opb_d       = opb_sav_q;
                    inp_valid_d = 2'b10;
                    state_d     = SEND_B;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SEND_B: begin
                cnt_d   = mul_q ? MUL_M1 : NORM_M1;
                state_d = WAIT;
            end
`else
            SEND: begin
                cnt_d   = mul_q ? MUL_M1 : NORM_M1;
                state_d = WAIT;
            end
`endif
            WAIT: begin
                if (cnt_q == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_res_d   = RES;
                    rsp_flags_d = {ERR, L, E, G, OFLOW, COUT};
                    ce_d        = 1'b0;
                    inp_valid_d = 2'b00;
                    if (ERR && err_cnt_q != 8'hFF)
                        err_cnt_d = err_cnt_q + 8'd1;
                    state_d     = HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

    // State and output registers; reset clears everything including req_ready
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mul_q       <= 1'b0;
            req_ready_q <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            cmd_q       <= '0;
            mode_q      <= 1'b0;
            cin_q       <= 1'b0;
            ce_q        <= 1'b0;
            inp_valid_q <= 2'b00;
            rsp_valid_q <= 1'b0;
            rsp_res_q   <= '0;
            rsp_flags_q <= '0;
            err_cnt_q   <= '0;
`ifdef ALU_ISSUE_SPLIT_EN
            opb_sav_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mul_q       <= mul_d;
            req_ready_q <= req_ready_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            cmd_q       <= cmd_d;
            mode_q      <= mode_d;
            cin_q       <= cin_d;
            ce_q        <= ce_d;
            inp_valid_q <= inp_valid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            rsp_flags_q <= rsp_flags_d;
            err_cnt_q   <= err_cnt_d;
`ifdef ALU_ISSUE_SPLIT_EN
            opb_sav_q   <= opb_sav_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign OPA       = opa_q;
    assign OPB       = opb_q;
    assign CMD       = cmd_q;
    assign MODE      = mode_q;
    assign CIN       = cin_q;
    assign CE        = ce_q;
    assign INP_VALID = inp_valid_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_flags = rsp_flags_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// tb_alu_op_issuer: randomized self-checking bench for alu_op_issuer.
// The ALU side only presents a correct RES/flags in the cycle before the expected sample edge.
`timescale 1ns/1ps
module tb_alu_op_issuer;

    localparam int W    = 8;
    localparam int CW   = 4;
    localparam int LN   = 1;
    localparam int LM   = 2;
    localparam int GAPN = 3;
`ifdef ALU_ISSUE_SPLIT_EN
    localparam int PRE  = 2 + GAPN;
`else
    localparam int PRE  = 1;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [W-1:0]  req_opa = '0;
    logic [W-1:0]  req_opb = '0;
    logic [CW-1:0] req_cmd = '0;
    logic          req_mode = 1'b0;
    logic          req_cin = 1'b0;
    logic [W-1:0]  OPA, OPB;
    logic [CW-1:0] CMD;
    logic          MODE, CIN, CE;
    logic [1:0]    INP_VALID;
    logic [2*W-1:0] RES = '0;
    logic          COUT = 0, OFLOW = 0, G = 0, E = 0, L = 0, ERR = 0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [2*W-1:0] rsp_res;
    logic [5:0]    rsp_flags;
    logic [7:0]    err_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int err_exp = 0;

    alu_op_issuer #(
        .WIDTH(W), .CMD_W(CW), .LAT_NORM(LN),
        .LAT_MUL(LM), .SPLIT_GAP(GAPN)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opa(req_opa), .req_opb(req_opb),
        .req_cmd(req_cmd), .req_mode(req_mode),
        .req_cin(req_cin),
        .OPA(OPA), .OPB(OPB), .CMD(CMD),
        .MODE(MODE), .CIN(CIN), .CE(CE),
        .INP_VALID(INP_VALID), .RES(RES),
        .COUT(COUT), .OFLOW(OFLOW), .G(G),
        .E(E), .L(L), .ERR(ERR),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_flags(rsp_flags),
        .err_cnt(err_cnt)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [2*W-1:0] alu_res(
        input logic [W-1:0] a, input logic [W-1:0] b,
        input logic [CW-1:0] c, input logic m, input logic ci);
        logic [2*W-1:0] r;
        if (m) begin
            case (c)
                4'd0:    r = 16'(a) + 16'(b);
                4'd1:    r = 16'(a) - 16'(b);
                4'd2:    r = 16'(a) + 16'(b) + 16'(ci);
                4'd9:    r = (16'(a) + 16'd1) * (16'(b) + 16'd1);
                4'd10:   r = (16'(a) << 1) * 16'(b);
                default: r = {a, b};
            endcase
        end else begin
            case (c)
                4'd0:    r = {8'h00, a & b};
                4'd1:    r = {8'h00, a | b};
                default: r = {8'h00, a ^ b};
            endcase
        end
        return r;
    endfunction

    function automatic logic [5:0] alu_flags(
        input logic [W-1:0] a, input logic [W-1:0] b, input logic e);
        logic [W:0] s;
        logic ofl;
        s   = {1'b0, a} + {1'b0, b};
        ofl = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return {e, a < b, a == b, a > b, ofl, s[W]};
    endfunction

    task automatic do_op(
        input logic [W-1:0] a, input logic [W-1:0] b,
        input logic [CW-1:0] c, input logic m, input logic ci,
        input logic e, input int hold);
        logic [2*W-1:0] good_r, junk_r;
        logic [5:0]     good_f, junk_f;
        logic [1:0]     iv_e;
        logic [W-1:0]   opb_e;
        int lat;
        int waitn;
        good_r = alu_res(a, b, c, m, ci);
        good_f = alu_flags(a, b, e);
        junk_r = ~good_r;
        junk_f = ~good_f;
        lat = (m && (c == 4'd9 || c == 4'd10)) ? LM : LN;
        RES = junk_r;
        {ERR, L, E, G, OFLOW, COUT} = junk_f;
        req_opa = a; req_opb = b; req_cmd = c;
        req_mode = m; req_cin = ci; req_valid = 1'b1;
        waitn = 0;
        while (req_ready !== 1'b1 && waitn < 20) begin
            tick;
            waitn++;
        end
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL accept_timeout: req_ready=%b want 1",
                     req_ready);
        end
        tick;
        req_valid = 1'b0;
        for (int k = 0; k < PRE + lat; k++) begin
`ifdef ALU_ISSUE_SPLIT_EN
            if (k == 0) begin
                iv_e = 2'b01; opb_e = '0;
            end else if (k <= GAPN) begin
                iv_e = 2'b00; opb_e = '0;
            end else begin
                iv_e = 2'b10; opb_e = b;
            end
`else
            iv_e = 2'b11; opb_e = b;
`endif
            n_cmp++;
            if ({CE, INP_VALID, OPA, OPB, CMD, MODE, CIN,
                 rsp_valid, req_ready} !==
                {1'b1, iv_e, a, opb_e, c, m, ci, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL issue_k%0d: ce=%b iv=%b opa=%h opb=%h cmd=%h m=%b ci=%b rv=%b rr=%b want ce=1 iv=%b opa=%h opb=%h cmd=%h m=%b ci=%b rv=0 rr=0",
                         k, CE, INP_VALID, OPA, OPB, CMD, MODE, CIN,
                         rsp_valid, req_ready, iv_e, a, opb_e, c, m, ci);
            end
            rsp_ready = 1'($urandom_range(0, 1));
            if (k == PRE + lat - 1) begin
                RES = good_r;
                {ERR, L, E, G, OFLOW, COUT} = good_f;
            end
            tick;
        end
        rsp_ready = 1'b0;
        RES = junk_r;
        {ERR, L, E, G, OFLOW, COUT} = junk_f;
        if (e && err_exp < 255) err_exp++;
        n_cmp++;
        if ({rsp_valid, req_ready, CE, INP_VALID, rsp_res,
             rsp_flags, err_cnt} !==
            {1'b1, 1'b0, 1'b0, 2'b00, good_r, good_f,
             8'(err_exp)}) begin
            n_bad++;
            $display("FAIL response: rv=%b rr=%b ce=%b iv=%b res=%h fl=%b ec=%0d want rv=1 rr=0 ce=0 iv=00 res=%h fl=%b ec=%0d",
                     rsp_valid, req_ready, CE, INP_VALID, rsp_res,
                     rsp_flags, err_cnt, good_r, good_f, err_exp);
        end
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            req_opa = W'($urandom);
            tick;
            n_cmp++;
            if ({rsp_valid, req_ready, CE, rsp_res, rsp_flags} !==
                {1'b1, 1'b0, 1'b0, good_r, good_f}) begin
                n_bad++;
                $display("FAIL hold_h%0d: rv=%b rr=%b ce=%b res=%h fl=%b want rv=1 rr=0 ce=0 res=%h fl=%b",
                         h, rsp_valid, req_ready, CE, rsp_res,
                         rsp_flags, good_r, good_f);
            end
        end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        n_cmp++;
        if ({rsp_valid, req_ready, CE, INP_VALID} !==
            {1'b0, 1'b1, 1'b0, 2'b00}) begin
            n_bad++;
            $display("FAIL release: rv=%b rr=%b ce=%b iv=%b want rv=0 rr=1 ce=0 iv=00",
                     rsp_valid, req_ready, CE, INP_VALID);
        end
    endtask

    task automatic test_reset;
        RST = 1'b0;
        #1;
        repeat (2) begin
            n_cmp++;
            if ({req_ready, OPA, OPB, CMD, MODE, CIN, CE, INP_VALID,
                 rsp_valid, rsp_res, rsp_flags, err_cnt} !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs: rr=%b ce=%b iv=%b rv=%b res=%h ec=%0d want all 0",
                         req_ready, CE, INP_VALID, rsp_valid,
                         rsp_res, err_cnt);
            end
            tick;
        end
        RST = 1'b1;
        tick;
        n_cmp++;
        if ({req_ready, CE, INP_VALID, rsp_valid, err_cnt} !==
            {1'b1, 1'b0, 2'b00, 1'b0, 8'd0}) begin
            n_bad++;
            $display("FAIL reset_release: rr=%b ce=%b iv=%b rv=%b ec=%0d want rr=1 others 0",
                     req_ready, CE, INP_VALID, rsp_valid, err_cnt);
        end
        err_exp = 0;
    endtask

    task automatic test_directed;
        do_op(8'h0F, 8'h01, 4'd0, 1'b1, 1'b0, 1'b0, 0);
        do_op(8'h03, 8'h04, 4'd9, 1'b1, 1'b0, 1'b0, 0);
        do_op(8'h03, 8'h04, 4'd9, 1'b0, 1'b0, 1'b0, 0);
        do_op(8'h07, 8'h05, 4'd10, 1'b1, 1'b1, 1'b1, 0);
    endtask

    task automatic test_backpressure;
        do_op(8'hA5, 8'h5A, 4'd2, 1'b1, 1'b1, 1'b0, 5);
        do_op(8'h80, 8'h80, 4'd0, 1'b1, 1'b0, 1'b0, 5);
    endtask

    task automatic test_random;
        logic [CW-1:0] c;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0)
                c = $urandom_range(0, 1) ? 4'd9 : 4'd10;
            else
                c = CW'($urandom);
            do_op(W'($urandom), W'($urandom), c,
                  1'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_mid;
        int waitn;
        req_opa = 8'h11; req_opb = 8'h22; req_cmd = 4'd0;
        req_mode = 1'b1; req_cin = 1'b0; req_valid = 1'b1;
        RES = 16'h0033;
        {ERR, L, E, G, OFLOW, COUT} = 6'b100000;
        waitn = 0;
        while (req_ready !== 1'b1 && waitn < 20) begin
            tick;
            waitn++;
        end
        tick;
        req_valid = 1'b0;
        tick;
        RST = 1'b0;
        #1;
        err_exp = 0;
        n_cmp++;
        if ({req_ready, OPA, OPB, CMD, MODE, CIN, CE, INP_VALID,
             rsp_valid, rsp_res, rsp_flags, err_cnt} !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: rr=%b ce=%b iv=%b rv=%b res=%h ec=%0d want all 0",
                     req_ready, CE, INP_VALID, rsp_valid,
                     rsp_res, err_cnt);
        end
        tick;
        RST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            n_cmp++;
            if ({rsp_valid, CE, INP_VALID, req_ready} !==
                {1'b0, 1'b0, 2'b00, 1'b1}) begin
                n_bad++;
                $display("FAIL midreset_idle%0d: rv=%b ce=%b iv=%b rr=%b want rv=0 ce=0 iv=00 rr=1",
                         i, rsp_valid, CE, INP_VALID, req_ready);
            end
        end
        do_op(8'h21, 8'h12, 4'd0, 1'b1, 1'b0, 1'b0, 1);
    endtask

    task automatic test_err_saturate;
        for (int i = 0; i < 300; i++)
            do_op(W'($urandom), W'($urandom), CW'($urandom),
                  1'($urandom), 1'($urandom), 1'b1, 0);
        n_cmp++;
        if (err_cnt !== 8'd255) begin
            n_bad++;
            $display("FAIL err_saturate: err_cnt=%0d want 255",
                     err_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_backpressure;
        test_random;
        test_reset_mid;
        test_err_saturate;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
